// File: rtl/eth_pkt_pkg.sv
// Shared definitions for the Ethernet packet FIFO read-side framer:
// header field position, word-count width, FSM encoding and keep lookup.
package eth_pkt_pkg;

  localparam int unsigned LEN_LSB = 0;
  localparam int unsigned LEN_W   = 16;
  localparam int unsigned WCNT_W  = 14;
  localparam int unsigned KEEP_W  = 4;
  localparam int unsigned CNT_W   = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_SEND = 2'd2;
  localparam logic [1:0] ST_DROP = 2'd3;

  // Byte-lane mask of the final word, from LEN modulo 4.
  function automatic logic [KEEP_W-1:0] keep_from_len(input logic [1:0] len_lsbs);
    case (len_lsbs)
      2'd1:    keep_from_len = 4'b0001;
      2'd2:    keep_from_len = 4'b0011;
      2'd3:    keep_from_len = 4'b0111;
      default: keep_from_len = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/eth_pkt_fifo_reader.sv
// Pops length-prefixed packets from a show-ahead FIFO and frames them as a
// valid/ready stream with keep/last; packets start only once fully resident.
module eth_pkt_fifo_reader
  import eth_pkt_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned MAX_LEN    = 1536
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_empty,
  input  logic [ADDR_WIDTH:0]   fifo_rd_water_level,
  output logic                  fifo_rd_en,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [KEEP_W-1:0]     m_keep,
  output logic                  m_last,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  err_len,
  output logic [CNT_W-1:0]      pkt_cnt,
  output logic [CNT_W-1:0]      drop_cnt
);

  logic [1:0]            r_state,     w_nxt_state;
  logic [WCNT_W-1:0]     r_remaining, w_nxt_remaining;
  logic [LEN_W-1:0]      r_len,       w_nxt_len;
  logic [DATA_WIDTH-1:0] r_data,      w_nxt_data;
  logic [KEEP_W-1:0]     r_keep,      w_nxt_keep;
  logic                  r_last,      w_nxt_last;
  logic                  r_valid,     w_nxt_valid;
  logic                  r_err,       w_nxt_err;
  logic [CNT_W-1:0]      r_pkt_cnt,   w_nxt_pkt_cnt;
  logic [CNT_W-1:0]      r_drop_cnt,  w_nxt_drop_cnt;

  logic [LEN_W-1:0]  w_hdr_len;
  logic [WCNT_W-1:0] w_hdr_words;
  logic              w_level_ok;
  logic              w_load_ok;

  assign w_hdr_len   = fifo_rd_data[LEN_LSB +: LEN_W];
  assign w_hdr_words = WCNT_W'((32'(w_hdr_len) + 32'd3) >> 2);
  assign w_level_ok  = 32'(fifo_rd_water_level) >= 32'(r_remaining);
  assign w_load_ok   = !r_valid || m_ready;

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      r_state     <= ST_IDLE;
      r_remaining <= '0;
      r_len       <= '0;
      r_data      <= '0;
      r_keep      <= '0;
      r_last      <= 1'b0;
      r_valid     <= 1'b0;
      r_err       <= 1'b0;
      r_pkt_cnt   <= '0;
      r_drop_cnt  <= '0;
    end else begin
      r_state     <= w_nxt_state;
      r_remaining <= w_nxt_remaining;
      r_len       <= w_nxt_len;
      r_data      <= w_nxt_data;
      r_keep      <= w_nxt_keep;
      r_last      <= w_nxt_last;
      r_valid     <= w_nxt_valid;
      r_err       <= w_nxt_err;
      r_pkt_cnt   <= w_nxt_pkt_cnt;
      r_drop_cnt  <= w_nxt_drop_cnt;
    end
  end

  always_comb begin
    w_nxt_state     = r_state;
    w_nxt_remaining = r_remaining;
    w_nxt_len       = r_len;
    w_nxt_data      = r_data;
    w_nxt_keep      = r_keep;
    w_nxt_last      = r_last;
    w_nxt_valid     = r_valid;
    w_nxt_err       = 1'b0;
    w_nxt_pkt_cnt   = r_pkt_cnt;
    w_nxt_drop_cnt  = r_drop_cnt;
    fifo_rd_en      = 1'b0;

    if (r_valid && m_ready) begin
      w_nxt_valid = 1'b0;
    end

    case (r_state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_rd_en      = 1'b1;
          w_nxt_len       = w_hdr_len;
          w_nxt_remaining = w_hdr_words;
          if (w_hdr_len == '0) begin
            w_nxt_err      = 1'b1;
            w_nxt_drop_cnt = r_drop_cnt + CNT_W'(1);
          end else if (32'(w_hdr_len) > 32'(MAX_LEN)) begin
            w_nxt_err   = 1'b1;
            w_nxt_state = ST_DROP;
          end else begin
            w_nxt_state = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (w_level_ok) begin
          w_nxt_state = ST_SEND;
        end
      end
      ST_SEND: begin
        // A reload may coincide with acceptance of the held word: no bubble.
        if (w_load_ok && !fifo_empty && (r_remaining != '0)) begin
          fifo_rd_en      = 1'b1;
          w_nxt_data      = fifo_rd_data;
          w_nxt_valid     = 1'b1;
          w_nxt_remaining = r_remaining - WCNT_W'(1);
          if (r_remaining == WCNT_W'(1)) begin
            w_nxt_last    = 1'b1;
            w_nxt_keep    = keep_from_len(r_len[1:0]);
            w_nxt_pkt_cnt = r_pkt_cnt + CNT_W'(1);
            w_nxt_state   = ST_IDLE;
          end else begin
            w_nxt_last = 1'b0;
            w_nxt_keep = '1;
          end
        end
      end
      ST_DROP: begin
        // A header whose word count wraps to zero terminates immediately.
        if (r_remaining == '0) begin
          w_nxt_drop_cnt = r_drop_cnt + CNT_W'(1);
          w_nxt_state    = ST_IDLE;
        end else if (!fifo_empty) begin
          fifo_rd_en      = 1'b1;
          w_nxt_remaining = r_remaining - WCNT_W'(1);
          if (r_remaining == WCNT_W'(1)) begin
            w_nxt_drop_cnt = r_drop_cnt + CNT_W'(1);
            w_nxt_state    = ST_IDLE;
          end
        end
      end
      default: begin
        w_nxt_state = ST_IDLE;
      end
    endcase

    if (rd_rst) begin
      fifo_rd_en = 1'b0;
    end
  end

  assign m_data   = r_data;
  assign m_keep   = r_keep;
  assign m_last   = r_last;
  assign m_valid  = r_valid;
  assign err_len  = r_err;
  assign pkt_cnt  = r_pkt_cnt;
  assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_eth_pkt_fifo_reader.sv
// Directed bench for eth_pkt_fifo_reader: show-ahead FIFO model feeding the
// reader, expected-beat queue built from each header's LEN.
module tb_eth_pkt_fifo_reader;

  localparam int unsigned AW    = 10;
  localparam int unsigned LVL_W = AW + 1;

  logic              rd_clk = 1'b0;
  logic              rd_rst;
  logic [31:0]       fifo_rd_data;
  logic              fifo_empty;
  logic [LVL_W-1:0]  fifo_rd_water_level;
  logic              fifo_rd_en;
  logic [31:0]       m_data;
  logic [3:0]        m_keep;
  logic              m_last;
  logic              m_valid;
  logic              m_ready;
  logic              err_len;
  logic [15:0]       pkt_cnt;
  logic [15:0]       drop_cnt;

  always #5 rd_clk = ~rd_clk;

  eth_pkt_fifo_reader #(.DATA_WIDTH(32), .ADDR_WIDTH(AW), .MAX_LEN(1536)) dut (
    .rd_clk(rd_clk), .rd_rst(rd_rst),
    .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty),
    .fifo_rd_water_level(fifo_rd_water_level), .fifo_rd_en(fifo_rd_en),
    .m_data(m_data), .m_keep(m_keep), .m_last(m_last), .m_valid(m_valid),
    .m_ready(m_ready), .err_len(err_len), .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
  );

  // Show-ahead FIFO model
  logic [31:0] mem [0:4095];
  logic [31:0] wr_ptr;
  logic [31:0] rd_ptr;
  logic        flush;

  assign fifo_empty          = (wr_ptr == rd_ptr);
  assign fifo_rd_data        = mem[rd_ptr[11:0]];
  assign fifo_rd_water_level = LVL_W'(wr_ptr - rd_ptr);

  always @(posedge rd_clk) begin
    if (flush)           rd_ptr <= wr_ptr;
    else if (fifo_rd_en) rd_ptr <= rd_ptr + 32'd1;
  end

  int n_vec = 0;
  int n_err = 0;
  logic [36:0] exp_q[$];
  logic        mon_en = 1'b0;
  logic        tog_en = 1'b0;
  logic        b2b_arm = 1'b0;
  logic        b2b_seen = 1'b0;
  logic        prev_stall = 1'b0;
  logic [36:0] prev_beat = '0;
  int          err_seen = 0;
  int          beats = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic monitor();
    logic [36:0] e;
    if (!mon_en) return;
    chk("pop_guard", 64'(fifo_rd_en & fifo_empty), 64'd0);
    if (err_len) err_seen++;
    if (!b2b_arm) b2b_seen = 1'b0;
    else if (m_valid && m_last && fifo_rd_en && fifo_rd_data[15:0] == 16'd7) b2b_seen = 1'b1;
    if (prev_stall && !rd_rst)
      chk("hold", 64'({m_valid, m_last, m_keep, m_data}), 64'({1'b1, prev_beat}));
    if (m_valid && m_ready) begin
      beats++;
      if (exp_q.size() == 0) chk("extra_beat", 64'({m_last, m_keep, m_data}), 64'd0);
      else begin
        e = exp_q.pop_front();
        chk("beat", 64'({m_last, m_keep, m_data}), 64'(e));
      end
    end
    prev_stall = m_valid && !m_ready && !rd_rst;
    prev_beat  = {m_last, m_keep, m_data};
  endtask

  task automatic tick();
    @(negedge rd_clk);
    monitor();
    @(posedge rd_clk);
    #1;
    if (tog_en) m_ready = ~m_ready;
  endtask

  task automatic push(input logic [31:0] w);
    mem[wr_ptr[11:0]] = w;
    wr_ptr = wr_ptr + 32'd1;
  endtask

  // Pushes header plus the first nw data words; queues all expected beats.
  task automatic push_pkt(input int len, input int nw, input logic [31:0] base, input bit expect_beats);
    int w;
    int lanes;
    logic [3:0] k;
    w = (len + 3) / 4;
    push(32'hBEEF_0000 | 32'(len));
    for (int i = 0; i < nw; i++) push(base + 32'(i));
    if (expect_beats) begin
      for (int i = 0; i < w; i++) begin
        if (i == w - 1) begin
          lanes = len - 4 * (w - 1);
          k = 4'((1 << lanes) - 1);
          exp_q.push_back({1'b1, k, base + 32'(i)});
        end else begin
          exp_q.push_back({1'b0, 4'hF, base + 32'(i)});
        end
      end
    end
  endtask

  task automatic drain(input int bound);
    bit done = 0;
    for (int i = 0; i < bound; i++) begin
      if (exp_q.size() == 0 && rd_ptr == wr_ptr && !m_valid) begin
        done = 1;
        break;
      end
      tick();
    end
    if (!done) chk("drain_timeout", 64'd0, 64'd1);
    tick();
    tick();
  endtask

  initial begin
    logic [31:0] p0;
    int err0;
    int b0;
    bit got3;
    wr_ptr = '0;
    rd_rst = 1'b1;
    flush = 1'b1;
    m_ready = 1'b1;
    tick();
    tick();
    chk("rst_rden", 64'(fifo_rd_en), 64'd0);
    rd_rst = 1'b0;
    flush = 1'b0;
    #1;
    chk("rst_valid", 64'(m_valid), 64'd0);
    chk("rst_last",  64'(m_last),  64'd0);
    chk("rst_keep",  64'(m_keep),  64'd0);
    chk("rst_data",  64'(m_data),  64'd0);
    chk("rst_err",   64'(err_len), 64'd0);
    chk("rst_pkt",   64'(pkt_cnt), 64'd0);
    chk("rst_drop",  64'(drop_cnt), 64'd0);
    mon_en = 1'b1;

    // LEN=10, three data words: latency and partial keep
    push_pkt(10, 3, 32'hA000_0000, 1);
    #1;
    chk("t1_hdr_pop", 64'(fifo_rd_en), 64'd1);
    tick();
    chk("t1_wait_nopop", 64'(fifo_rd_en), 64'd0);
    chk("t1_wait_valid", 64'(m_valid), 64'd0);
    tick();
    chk("t1_first_pop", 64'(fifo_rd_en), 64'd1);
    chk("t1_n2_valid", 64'(m_valid), 64'd0);
    tick();
    chk("t1_first_valid", 64'(m_valid), 64'd1);
    drain(50);
    chk("t1_pkt_cnt", 64'(pkt_cnt), 64'd1);

    // LEN=8 with one word resident; second arrives 20 cycles later
    p0 = wr_ptr;
    push_pkt(8, 1, 32'hB000_0000, 1);
    for (int i = 0; i < 20; i++) tick();
    chk("t2_pops_waiting", 64'(rd_ptr - p0), 64'd1);
    chk("t2_no_valid", 64'(m_valid), 64'd0);
    push(32'hB000_0001);
    drain(50);
    chk("t2_pkt_cnt", 64'(pkt_cnt), 64'd2);

    // LEN=64 with m_ready toggling
    tog_en = 1'b1;
    push_pkt(64, 16, 32'hC000_0000, 1);
    drain(200);
    tog_en = 1'b0;
    m_ready = 1'b1;
    chk("t3_pkt_cnt", 64'(pkt_cnt), 64'd3);

    // LEN=0, oversize LEN=2000, then LEN=4
    err0 = err_seen;
    push_pkt(0, 0, 32'h0, 0);
    push_pkt(2000, 500, 32'hD000_0000, 0);
    push_pkt(4, 1, 32'hE000_0000, 1);
    drain(1500);
    chk("t4_err_pulses", 64'(err_seen - err0), 64'd2);
    chk("t4_drop_cnt", 64'(drop_cnt), 64'd2);
    chk("t4_pkt_cnt", 64'(pkt_cnt), 64'd4);

    // Back-to-back LEN=5 and LEN=7
    b2b_arm = 1'b1;
    push_pkt(5, 2, 32'hF000_0000, 1);
    push_pkt(7, 2, 32'hF100_0000, 1);
    drain(100);
    chk("t5_b2b_hdr_pop", 64'(b2b_seen), 64'd1);
    chk("t5_pkt_cnt", 64'(pkt_cnt), 64'd6);
    b2b_arm = 1'b0;

    // Reset mid-SEND, then a clean packet
    b0 = beats;
    got3 = 0;
    push_pkt(64, 16, 32'h1200_0000, 1);
    for (int i = 0; i < 100; i++) begin
      if (beats - b0 >= 3) begin
        got3 = 1;
        break;
      end
      tick();
    end
    chk("t6_reached_send", 64'(got3), 64'd1);
    rd_rst = 1'b1;
    flush = 1'b1;
    #1;
    chk("t6_rst_rden", 64'(fifo_rd_en), 64'd0);
    tick();
    rd_rst = 1'b0;
    flush = 1'b0;
    exp_q.delete();
    #1;
    chk("t6_valid", 64'(m_valid), 64'd0);
    chk("t6_last",  64'(m_last),  64'd0);
    chk("t6_keep",  64'(m_keep),  64'd0);
    chk("t6_data",  64'(m_data),  64'd0);
    chk("t6_err",   64'(err_len), 64'd0);
    chk("t6_pkt",   64'(pkt_cnt), 64'd0);
    chk("t6_drop",  64'(drop_cnt), 64'd0);
    push_pkt(3, 1, 32'h1300_0000, 1);
    drain(50);
    chk("t6_clean_pkt", 64'(pkt_cnt), 64'd1);
    chk("t6_clean_drop", 64'(drop_cnt), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
